// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: whole-cycle round-robin grant, response routed to the
// granted master, with a stall timeout that aborts a hung strobe and latches its address.
module wb_arbiter2 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] fault_adr_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t                r_state, w_next;
  logic                  r_last;
  logic [15:0]           r_cnt;
  logic [ADDR_WIDTH-1:0] r_fault_adr;

  logic                  w_g0, w_g1;
  logic                  w_cyc, w_stb, w_stall, w_abort;
  logic [ADDR_WIDTH-1:0] w_adr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0) r_last <= 1'b0;
      else if (w_next == GNT1) r_last <= 1'b1;
    end
  end

  // On a tie out of IDLE the master that did not own the bus last wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_next = r_last ? GNT0 : GNT1;
        else if (m0_cyc_i)        w_next = GNT0;
        else if (m1_cyc_i)        w_next = GNT1;
      end
      GNT0:    if (!m0_cyc_i) w_next = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) w_next = m0_cyc_i ? GNT0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_g0 = (r_state == GNT0);
  assign w_g1 = (r_state == GNT1);

  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    s_we_o  = 1'b0;
    w_adr   = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_g0) begin
      w_cyc   = m0_cyc_i;
      w_stb   = m0_stb_i;
      s_we_o  = m0_we_i;
      w_adr   = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_g1) begin
      w_cyc   = m1_cyc_i;
      w_stb   = m1_stb_i;
      s_we_o  = m1_we_i;
      w_adr   = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // An ack in the boundary cycle removes the stall, so it always beats the abort.
  assign w_stall = w_stb & ~s_ack_i;
  assign w_abort = (TIMEOUT != 0) && w_stall && (r_cnt == TO_CNT);

  assign s_cyc_o   = w_cyc & ~w_abort;
  assign s_stb_o   = w_stb & ~w_abort;
  assign s_adr_o   = w_adr;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = s_ack_i & w_g0;
  assign m1_ack_o  = s_ack_i & w_g1;
  assign m0_err_o  = w_abort & w_g0;
  assign m1_err_o  = w_abort & w_g1;
  assign timeout_o = w_abort;
  assign grant_o   = {w_g1, w_g0};
  assign fault_adr_o = r_fault_adr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_fault_adr <= '0;
    end else begin
      if (!w_stall || w_abort || (w_next != r_state)) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + 16'd1;
      if (w_abort) r_fault_adr <= w_adr;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scenario bench for wb_arbiter2: expected acks are queued when the slave responds and
// matched by a monitor; grant, abort and reset behaviour are checked inline per task.
module tb_wb_arbiter2;
  localparam int DW = 16, AW = 32, SW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_dat = '0, m1_dat = '0, s_dat_i = '0;
  logic [SW-1:0] m0_sel = '0, m1_sel = '0;
  logic s_ack_i = 0;
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [AW-1:0] s_adr_o, fault_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [1:0] grant_o;

  typedef struct packed {logic mst; logic [DW-1:0] dat;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .fault_adr_o(fault_adr_o)
  );

  always #5 clk = ~clk;

  // Ack monitor: every ack seen by a master must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_ack_o || m1_ack_o)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected got m0=%b m1=%b", m0_ack_o, m1_ack_o);
      end else begin
        e = q.pop_front();
        if ((m0_ack_o && m1_ack_o) || m1_ack_o !== e.mst ||
            (m1_ack_o ? m1_dat_o : m0_dat_o) !== e.dat) begin
          bad++;
          $display("FAIL ack_route got m0=%b m1=%b dat0=%h dat1=%h exp mst=%0d dat=%h",
                   m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o, e.mst, e.dat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1 total++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 10'b0 ||
        fault_adr_o !== '0 || s_adr_o !== '0) begin
      bad++;
      $display("FAIL reset_state got gnt=%b cyc=%b stb=%b to=%b fadr=%h adr=%h exp all zero",
               grant_o, s_cyc_o, s_stb_o, timeout_o, fault_adr_o, s_adr_o);
    end
  endtask

  task automatic test_single();
    step();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 2'b11; m0_adr = 32'h0000_1000;
    #1 total++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL single_latency got gnt=%b cyc=%b exp 00/0", grant_o, s_cyc_o);
    end
    step(); total++;
    if (grant_o !== 2'b01 || {s_cyc_o, s_stb_o} !== 2'b11 || s_adr_o !== 32'h0000_1000 || s_sel_o !== 2'b11) begin
      bad++; $display("FAIL single_grant got gnt=%b cyc=%b stb=%b adr=%h exp 01/1/1/00001000",
                      grant_o, s_cyc_o, s_stb_o, s_adr_o);
    end
    step(); step();
    s_ack_i = 1; s_dat_i = 16'hBEEF; q.push_back('{1'b0, 16'hBEEF});
    #1 total++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== 16'hBEEF) begin
      bad++; $display("FAIL single_ack got ack0=%b ack1=%b dat=%h exp 1/0/beef", m0_ack_o, m1_ack_o, m0_dat_o);
    end
    step();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    #1 total++;
    if (m0_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL single_release got ack0=%b cyc=%b exp 0/0", m0_ack_o, s_cyc_o);
    end
    step(); total++;
    if (grant_o !== 2'b00) begin
      bad++; $display("FAIL single_idle got gnt=%b exp 00", grant_o);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    step(); total++;
    if (grant_o !== 2'b01 || s_adr_o !== 32'h100) begin
      bad++; $display("FAIL tie_first got gnt=%b adr=%h exp 01/100", grant_o, s_adr_o);
    end
    s_ack_i = 1; s_dat_i = 16'h1111; q.push_back('{1'b0, 16'h1111});
    step();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    #1 total++;
    if (grant_o !== 2'b01 || s_cyc_o !== 1'b0) begin
      bad++; $display("FAIL tie_drop got gnt=%b cyc=%b exp 01/0", grant_o, s_cyc_o);
    end
    step(); total++;
    if (grant_o !== 2'b10 || s_adr_o !== 32'h200 || s_cyc_o !== 1'b1) begin
      bad++; $display("FAIL tie_handoff got gnt=%b adr=%h cyc=%b exp 10/200/1", grant_o, s_adr_o, s_cyc_o);
    end
    s_ack_i = 1; s_dat_i = 16'h2222; q.push_back('{1'b1, 16'h2222});
    #1 total++;
    if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
      bad++; $display("FAIL tie_ack1 got ack0=%b ack1=%b exp 0/1", m0_ack_o, m1_ack_o);
    end
    step();
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
    step();
    m0_cyc = 1; m1_cyc = 1;
    step(); total++;
    if (grant_o !== 2'b01) begin
      bad++; $display("FAIL tie_second got gnt=%b exp 01", grant_o);
    end
    m0_cyc = 0; m1_cyc = 0;
    step(); step();
  endtask

  task automatic test_lock();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h5000_0000; m1_dat = 16'h0F0F;
    step();
    for (int k = 0; k < 4; k++) begin
      m1_adr = 32'h5000_0000 + 32'(2 * k);
      s_ack_i = 1; s_dat_i = 16'h00A0 + 16'(k); q.push_back('{1'b1, 16'h00A0 + 16'(k)});
      if (k == 1) begin m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600; end
      #1 total++;
      if (grant_o !== 2'b10 || s_adr_o !== 32'h5000_0000 + 32'(2 * k) || s_we_o !== 1'b1 || m0_ack_o !== 1'b0) begin
        bad++; $display("FAIL lock_beat%0d got gnt=%b adr=%h we=%b ack0=%b exp 10/%h/1/0",
                        k, grant_o, s_adr_o, s_we_o, m0_ack_o, 32'h5000_0000 + 32'(2 * k));
      end
      step();
    end
    s_ack_i = 0; m1_cyc = 0; m1_stb = 0;
    step(); total++;
    if (grant_o !== 2'b01 || s_adr_o !== 32'h600) begin
      bad++; $display("FAIL lock_after got gnt=%b adr=%h exp 01/600", grant_o, s_adr_o);
    end
    m0_cyc = 0; m0_stb = 0;
    step(); step();
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0010;
    step();
    for (int i = 0; i < 8; i++) begin
      #1 total++;
      if ({m0_err_o, timeout_o, s_stb_o} !== 3'b001) begin
        bad++; $display("FAIL timeout_early%0d got err=%b to=%b stb=%b exp 0/0/1", i, m0_err_o, timeout_o, s_stb_o);
      end
      step();
    end
    #1 total++;
    if ({m0_err_o, timeout_o, s_stb_o, s_cyc_o, m1_err_o} !== 5'b11000) begin
      bad++; $display("FAIL timeout_abort got err=%b to=%b stb=%b cyc=%b err1=%b exp 1/1/0/0/0",
                      m0_err_o, timeout_o, s_stb_o, s_cyc_o, m1_err_o);
    end
    step(); total++;
    if (fault_adr_o !== 32'h3000_0010 || m0_err_o !== 1'b0 || timeout_o !== 1'b0 ||
        s_stb_o !== 1'b1 || grant_o !== 2'b01) begin
      bad++; $display("FAIL timeout_after got fadr=%h err=%b to=%b stb=%b gnt=%b exp 30000010/0/0/1/01",
                      fault_adr_o, m0_err_o, timeout_o, s_stb_o, grant_o);
    end
    m0_cyc = 0; m0_stb = 0;
    step(); step();
  endtask

  task automatic test_boundary();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0020;
    step();
    for (int i = 0; i < 8; i++) step();
    s_ack_i = 1; s_dat_i = 16'h7777; q.push_back('{1'b0, 16'h7777});
    #1 total++;
    if ({m0_ack_o, m0_err_o, timeout_o, s_stb_o} !== 4'b1001) begin
      bad++; $display("FAIL boundary_ack got ack=%b err=%b to=%b stb=%b exp 1/0/0/1",
                      m0_ack_o, m0_err_o, timeout_o, s_stb_o);
    end
    step();
    s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
    #1 total++;
    if (fault_adr_o !== 32'h3000_0010) begin
      bad++; $display("FAIL boundary_fault got fadr=%h exp 30000010", fault_adr_o);
    end
    step(); step();
  endtask

  task automatic test_async_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h7000;
    step(); total++;
    if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
      bad++; $display("FAIL areset_pre got gnt=%b cyc=%b exp 10/1", grant_o, s_cyc_o);
    end
    #2 rst = 1'b1; s_ack_i = 1;
    #1 total++;
    if ({grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_ack_o} !== 7'b0) begin
      bad++; $display("FAIL areset_mid got gnt=%b cyc=%b stb=%b ack1=%b err1=%b exp all zero",
                      grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o);
    end
    s_ack_i = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 total++;
    if (grant_o !== 2'b00) begin
      bad++; $display("FAIL areset_release got gnt=%b exp 00", grant_o);
    end
    step(); total++;
    if (grant_o !== 2'b10 || s_adr_o !== 32'h7000) begin
      bad++; $display("FAIL areset_regrant got gnt=%b adr=%h exp 10/7000", grant_o, s_adr_o);
    end
    m1_cyc = 0; m1_stb = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_timeout();
    test_boundary();
    test_async_reset();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL ack_missing got pending=%0d exp 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter that shares the single master port of the SoC bus interconnect between the CPU core (master 0) and the GDB target-engine UART (master 1). It grants the bus for whole `cyc` cycles using round-robin priority and routes the slave response back to the granted master only. A built-in stall timeout aborts any granted transfer that receives no `ack`, reporting the failing address.

## Interface
- `DATA_WIDTH`, default 16: width of the data bus.
- `ADDR_WIDTH`, default 32: width of the address bus.
- `SEL_WIDTH`, default 2: width of the byte select.
- `TIMEOUT`, default 255: number of stalled strobe cycles before abort. 0 disables the timeout. Maximum is 65535.
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`, in, 1 each: master 0 request.
- `m0_adr_i`, in, ADDR_WIDTH. `m0_dat_i`, in, DATA_WIDTH. `m0_sel_i`, in, SEL_WIDTH.
- `m0_dat_o`, out, DATA_WIDTH. `m0_ack_o`, `m0_err_o`, out, 1 each.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, out, 1 each: to the interconnect master port.
- `s_adr_o`, out, ADDR_WIDTH. `s_dat_o`, out, DATA_WIDTH. `s_sel_o`, out, SEL_WIDTH.
- `s_dat_i`, in, DATA_WIDTH. `s_ack_i`, in, 1.
- `grant_o`, out, 2: one-hot current grant; 00 when idle.
- `timeout_o`, out, 1: one-cycle pulse on abort.
- `fault_adr_o`, out, ADDR_WIDTH: address of the most recent aborted transfer.

## Operation
- States are IDLE, GNT0 and GNT1. The state register and the priority pointer `last` (which master was granted most recently) are both registered.
- In IDLE:
  - Only mX_cyc high: go to GNTX.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- In GNTX:
  - Hold the grant while mX_cyc is high. The other master's request is ignored.
  - When mX_cyc falls: if the other master's cyc is high, go directly to GNTother; otherwise go to IDLE.
  - Set `last` to X on every entry to GNTX.
- Slave-side outputs:
  - In GNTX, s_cyc/stb/we/adr/dat/sel are combinationally equal to master X's signals.
  - In IDLE, s_cyc_o and s_stb_o are 0; the other slave-side outputs are don't-care but driven to 0.
- Master-side outputs:
  - mX_ack_o = s_ack_i gated by the GNTX state. The non-granted master always sees ack=0 and err=0.
  - m0_dat_o and m1_dat_o are both driven from s_dat_i (broadcast).
- Timeout counter:
  - 16 bits wide.
  - Clears when s_stb_o is low, when s_ack_i is high, or on any grant change.
  - Increments each cycle that s_stb_o=1 and s_ack_i=0.
- Abort, when TIMEOUT≠0 and the counter equals TIMEOUT while stalled:
  - In that same cycle, force s_cyc_o and s_stb_o to 0, assert mX_err_o=1, and pulse timeout_o.
  - Register fault_adr_o ← s_adr_o.
  - Clear the counter.
  - The grant stays with X until mX_cyc falls, as normal.
  - An ack arriving in the abort cycle wins: no err is issued and no abort occurs.
- Reset values: state IDLE, `last`=1 (so master 0 wins the first tie), grant_o=00, counter=0, timeout_o=0, fault_adr_o=0. All s_* and m*_ack/err outputs are 0.
- Reset asserted mid-transfer: the grant is dropped immediately (asynchronously), with no err and no ack issued.

## Timing
- Arbitration latency is 1 cycle: cyc is seen in IDLE at edge N, and s_cyc_o is asserted after edge N+1.
- Handoff from GNTX to GNTother when mX_cyc falls: the other master is driven on the next cycle, with no IDLE bubble.
- Ack path is combinational: ack reaches the granted master in the same cycle as s_ack_i. Response latency is therefore exactly the slave's latency.
- Abort fires in the cycle where the counter equals TIMEOUT, i.e. stb has been stalled for TIMEOUT+1 cycles. err is high for exactly 1 cycle.
- A master that keeps cyc high after err may issue new strobes. The counter restarts from 0 for them.

## Test plan
- Single master, no contention: m0 read of 0x00001000, slave acks after 2 cycles → grant_o=01 one cycle after cyc, m0_ack_o high for 1 cycle with s_dat_i value, m1_ack_o=0 throughout.
- Simultaneous request out of reset: m0 and m1 cyc rise together → GNT0 first. When m0_cyc falls, grant_o goes directly to 10 on the next cycle. On the next tie, m0 wins again because `last`=1.
- Grant lock: m1 granted for a 4-beat burst while m0 raises cyc mid-burst → s_adr_o tracks m1 for all 4 acks, and m0 is granted only after m1_cyc falls.
- Timeout: TIMEOUT=8, m0 strobes 0x3000_0010 with no ack → after 9 stalled cycles, m0_err_o=1 for 1 cycle, timeout_o pulses, fault_adr_o=0x3000_0010, and s_stb_o=0 in that cycle.
- Ack on the boundary: ack arrives in the cycle the counter equals TIMEOUT → m0_ack_o=1, m0_err_o=0, timeout_o=0, fault_adr_o unchanged.
- Async reset mid-transfer: rst_i asserted between clock edges during GNT1 → grant_o=00 and s_cyc_o=0 immediately, without waiting for an edge. After release, an m1-only request is granted 1 cycle later.
